// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO write/read controllers: pointer sizing and Gray coding.
package fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointers carry one extra wrap bit beyond the storage address.
    function automatic int ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [REQ_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [REQ_W-1:0]   grant_idx
);

    always_comb begin
        int               c;
        logic             found;
        logic [REQ_W-1:0] ci;
        grant     = '0;
        grant_idx = last;
        found     = 1'b0;
        c         = 0;
        ci        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c  = (int'(last) + i) % NUM_REQ;
            ci = REQ_W'(c);
            if (!found && req[ci]) begin
                found     = 1'b1;
                grant[ci] = enable;
                grant_idx = ci;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// FIFO write-side controller: round-robin producer arbitration, write pointer,
// read-pointer synchronizer and registered full flag.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    localparam int REQ_W     = clog2(NUM_REQ),
    localparam int PTR_W     = ptr_w(ADDR_WIDTH)
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [PTR_W-1:0]              rd_ptr_gray,
    output logic                          mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data,
    output logic                          fifo_full,
    output logic [PTR_W-1:0]              wr_ptr_gray,
    output logic [REQ_W-1:0]              grant_id
);

    // Handshake: a producer raises req_valid[i] with stable data and keeps it until
    // req_ready[i] is seen high in the same cycle; that cycle is the transfer.

    logic [PTR_W-1:0]   wr_bin;
    logic [PTR_W-1:0]   wr_bin_next;
    logic [PTR_W-1:0]   gnext;
    logic [PTR_W-1:0]   rq1;
    logic [PTR_W-1:0]   rq2;
    logic [PTR_W-1:0]   full_target;
    logic [NUM_REQ-1:0] grant;
    logic [REQ_W-1:0]   grant_idx;
    logic               xfer;

    assign xfer = (|req_valid) && !fifo_full && !wr_rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .enable    (xfer),
        .last      (grant_id),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready   = grant;
    assign mem_wr_en   = xfer;
    assign mem_wr_addr = wr_bin[ADDR_WIDTH-1:0];

    always_comb begin
        mem_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == REQ_W'(i)) mem_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign wr_bin_next = xfer ? wr_bin + PTR_W'(1) : wr_bin;
    assign gnext       = PTR_W'(bin2gray(32'(wr_bin_next)));
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign full_target = {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]};

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_bin      <= '0;
            wr_ptr_gray <= '0;
            rq1         <= '0;
            rq2         <= '0;
            fifo_full   <= 1'b0;
            grant_id    <= REQ_W'(NUM_REQ - 1);
        end else begin
            rq1         <= rd_ptr_gray;
            rq2         <= rq1;
            wr_bin      <= wr_bin_next;
            wr_ptr_gray <= gnext;
            fifo_full   <= (gnext == full_target);
            if (xfer) grant_id <= grant_idx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin, fill/full, drain/wrap, mid-op reset.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 4;

    logic            wr_clk;
    logic            wr_rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [AW:0]     rd_ptr_gray;
    logic            mem_wr_en;
    logic [AW-1:0]   mem_wr_addr;
    logic [DW-1:0]   mem_wr_data;
    logic            fifo_full;
    logic [AW:0]     wr_ptr_gray;
    logic [1:0]      grant_id;

    int total;
    int bad;
    logic [DW-1:0] exp_q[$];

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_rst      (wr_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rd_ptr_gray (rd_ptr_gray),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .fifo_full   (fifo_full),
        .wr_ptr_gray (wr_ptr_gray),
        .grant_id    (grant_id)
    );

    // clock / reset
    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] slice(input int i);
        return req_data[i*DW +: DW];
    endfunction

    // scoreboard: every write seen at the array is matched against the expected queue
    always @(negedge wr_clk) begin
        if (mem_wr_en) begin
            if (exp_q.size() == 0) check("unexpected_wr", 32'(mem_wr_data), 32'hFFFF_FFFF);
            else check("wr_data", 32'(mem_wr_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int n;
        total       = 0;
        bad         = 0;
        wr_rst      = 1'b1;
        req_valid   = 4'b1111;
        req_data    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        rd_ptr_gray = '0;

        // reset with all producers requesting
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 0);
        check("rst_wr_en", 32'(mem_wr_en), 0);
        check("rst_gray", 32'(wr_ptr_gray), 0);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_grant_id", 32'(grant_id), 3);

        // round-robin with all valid: 0,1,2,3
        wr_rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(slice(k));
            check("rr_ready", 32'(req_ready), 32'(1 << k));
            check("rr_wr_en", 32'(mem_wr_en), 1);
            check("rr_addr", 32'(mem_wr_addr), 32'(k));
            tick();
            check("rr_grant_id", 32'(grant_id), 32'(k));
        end
        check("rr_gray", 32'(wr_ptr_gray), 32'b00110);

        // idle producers skipped: 1,3,1,3
        req_valid = 4'b1010;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = (k % 2 == 0) ? 1 : 3;
            exp_q.push_back(slice(n));
            check("skip_ready", 32'(req_ready), 32'(1 << n));
            check("skip_addr", 32'(mem_wr_addr), 32'(4 + k));
            tick();
            check("skip_grant_id", 32'(grant_id), 32'(n));
        end
        check("skip_gray", 32'(wr_ptr_gray), 32'b01100);

        // fill from empty with a single producer
        wr_rst = 1'b1;
        tick();
        wr_rst    = 1'b0;
        req_valid = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            req_data[7:0] = 8'(8'h40 + k);
            #1;
            exp_q.push_back(8'(8'h40 + k));
            check("fill_ready", 32'(req_ready), 1);
            check("fill_addr", 32'(mem_wr_addr), 32'(k));
            check("fill_not_full", 32'(fifo_full), 0);
            tick();
        end
        req_data[7:0] = 8'h77;
        #1;
        check("full_flag", 32'(fifo_full), 1);
        check("full_gray", 32'(wr_ptr_gray), 32'b11000);
        check("full_no_ready", 32'(req_ready), 0);
        check("full_no_wr", 32'(mem_wr_en), 0);
        tick();
        check("full_hold_gray", 32'(wr_ptr_gray), 32'b11000);
        check("full_hold_grant", 32'(grant_id), 0);
        check("full_still", 32'(fifo_full), 1);

        // drain one word: read pointer moves to 1
        rd_ptr_gray = 5'b00001;
        n = 0;
        while (fifo_full && n < 8) begin
            tick();
            n++;
        end
        check("drain_latency_ok", 32'(n >= 2 && n <= 3), 1);
        exp_q.push_back(8'h77);
        check("drain_wr_en", 32'(mem_wr_en), 1);
        check("drain_addr", 32'(mem_wr_addr), 0);
        check("drain_ready", 32'(req_ready), 1);
        tick();
        check("drain_gray", 32'(wr_ptr_gray), 32'b11001);
        check("drain_refull", 32'(fifo_full), 1);

        // mid-operation reset while streaming at addr 7
        rd_ptr_gray = '0;
        wr_rst      = 1'b1;
        tick();
        wr_rst    = 1'b0;
        req_valid = 4'b1111;
        req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        #1;
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back(slice(k % 4));
            tick();
        end
        check("mid_addr7", 32'(mem_wr_addr), 7);
        check("mid_wr_en", 32'(mem_wr_en), 1);
        wr_rst = 1'b1;
        #1;
        check("mid_rst_no_wr", 32'(mem_wr_en), 0);
        check("mid_rst_no_ready", 32'(req_ready), 0);
        tick();
        wr_rst = 1'b0;
        #1;
        exp_q.push_back(slice(0));
        check("mid_addr0", 32'(mem_wr_addr), 0);
        check("mid_full", 32'(fifo_full), 0);
        check("mid_grant_id", 32'(grant_id), 3);
        check("mid_gray", 32'(wr_ptr_gray), 0);
        check("mid_ready", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
